mem_interface: RTL

Memory access sequencer sitting directly upstream of the 512 x 32 synchronous RAM. Holds the CPU-side memory address register (MAR) and memory data register (MDR), loads both from the datapath bus, and sequences one-cycle RAM read and write strobes. A Read/Write/Done handshake lets the control unit step through each access. The MDR contents are returned to the bus mux.

---
 rtl/mem_interface.sv | 95 +++++++++
 1 files changed

// File: rtl/mem_interface.sv
// Memory access sequencer in front of the 512 x 32 synchronous RAM.
// Holds MAR/MDR, loads them from the datapath bus while idle, and issues
// one-cycle RAM read/write strobes with a Done pulse per completed access.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting; MAR/MDR loads accepted, Read/Write sampled
// RD_REQ | MemRead strobe high; RAM registers data at closing edge
// RD_CAP | RAM data valid on MemDataIn; captured into MDR at closing edge
// WR_REQ | MemWrite strobe high with MAR/MDR presented to RAM
// DONE   | Done pulse; MDRout holds the result of the access
module mem_interface #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  input  logic [DATA_W-1:0] MemDataIn,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemDataOut,
  output logic [DATA_W-1:0] MDRout,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_REQ = 3'd1,
    RD_CAP = 3'd2,
    WR_REQ = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;

  // State and data registers; reset aborts any access in flight.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
    end
  end

  // Next-state and register-load decode. Loads are honoured only in IDLE,
  // so a load in the same cycle as a request is seen by that access, and
  // MDRin can never race the read capture in RD_CAP.
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    unique case (state_q)
      IDLE: begin
        if (MARin) mar_d = BusMuxOut[ADDR_W-1:0];
        if (MDRin) mdr_d = BusMuxOut;
        // Read wins over a simultaneous Write; the write is dropped.
        if (Read)       state_d = RD_REQ;
        else if (Write) state_d = WR_REQ;
      end
      RD_REQ: state_d = RD_CAP;
      RD_CAP: begin
        mdr_d   = MemDataIn;
        state_d = DONE;
      end
      WR_REQ: state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded purely from registered state, so strobes are clean.
  always_comb begin
    MemRead    = (state_q == RD_REQ);
    MemWrite   = (state_q == WR_REQ);
    Busy       = (state_q != IDLE);
    Done       = (state_q == DONE);
    MemAddress = mar_q;
    MemDataOut = mdr_q;
    MDRout     = mdr_q;
  end

endmodule
